// File: rtl/stopwatch_timer.sv
// BCD stopwatch / countdown core for the 7seg9 display chain.
// Up/down counting with lap hold, clamped preset load and expiry flag.
module stopwatch_timer #(
  parameter int CLK_FREQ = 10_000_000,
  parameter int TICK_HZ  = 10,
  parameter int HOUR_MAX = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_stop,
  input  logic        lap,
  input  logic        clear,
  input  logic        load,
  input  logic [27:0] load_val,
  input  logic        mode,
  output logic [27:0] disp_bcd,
  output logic        running,
  output logic        lap_hold,
  output logic        expired,
  output logic        wrapped,
  output logic        update
);

  localparam int N  = CLK_FREQ / TICK_HZ;
  localparam int PW = $clog2(N);
  localparam logic [PW-1:0] PMAX = PW'(N - 1);
  localparam logic [7:0] HMAX = {4'(HOUR_MAX / 10), 4'(HOUR_MAX % 10)};
  localparam logic [27:0] MAXV = {HMAX, 20'h59599};

  typedef enum logic [1:0] {
    STOPPED,
    RUNNING,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [27:0]   value_q, value_d;
  logic [27:0]   snap_q, snap_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          lap_q, lap_d;
  logic          exp_q, exp_d;
  logic          wrap_q, wrap_d;
  logic          upd_q, upd_d;
  logic [27:0]   disp_d;
  logic          start_ok, stop_now, tick;

  // {borrow/carry, new digit}
  function automatic logic [4:0] dstep(
    input logic [3:0] d,
    input logic [3:0] lim,
    input logic       dn,
    input logic       en
  );
    logic [4:0] r;
    r = {1'b0, d};
    if (en) begin
      if (!dn) r = (d >= lim) ? 5'b10000 : {1'b0, d + 4'd1};
      else     r = (d == 4'd0) ? {1'b1, lim} : {1'b0, d - 4'd1};
    end
    return r;
  endfunction

  function automatic logic [27:0] step_val(
    input logic [27:0] v,
    input logic        dn
  );
    logic [4:0] t, s1, s10, m1, m10;
    logic [7:0] h;
    t   = dstep(v[3:0],   4'd9, dn, 1'b1);
    s1  = dstep(v[7:4],   4'd9, dn, t[4]);
    s10 = dstep(v[11:8],  4'd5, dn, s1[4]);
    m1  = dstep(v[15:12], 4'd9, dn, s10[4]);
    m10 = dstep(v[19:16], 4'd5, dn, m1[4]);
    h   = v[27:20];
    if (m10[4]) begin
      if (!dn) begin
        if (h >= HMAX)            h = 8'h00;
        else if (h[3:0] >= 4'd9)  h = {h[7:4] + 4'd1, 4'd0};
        else                      h = {h[7:4], h[3:0] + 4'd1};
      end else begin
        if (h == 8'h00)           h = HMAX;
        else if (h[3:0] == 4'd0)  h = {h[7:4] - 4'd1, 4'd9};
        else                      h = {h[7:4], h[3:0] - 4'd1};
      end
    end
    return {h, m10[3:0], m1[3:0], s10[3:0], s1[3:0], t[3:0]};
  endfunction

  function automatic logic [3:0] sat(
    input logic [3:0] d,
    input logic [3:0] lim
  );
    return (d > lim) ? lim : d;
  endfunction

  function automatic logic [27:0] clampv(input logic [27:0] v);
    logic [7:0] h;
    h = {sat(v[27:24], 4'd9), sat(v[23:20], 4'd9)};
    if (h > HMAX) h = HMAX;
    return {h,
            sat(v[19:16], 4'd5), sat(v[15:12], 4'd9),
            sat(v[11:8],  4'd5), sat(v[7:4],   4'd9),
            sat(v[3:0],   4'd9)};
  endfunction

  assign start_ok = start_stop && (state_q == STOPPED) &&
                    !(mode && (value_q == '0));
  assign stop_now = start_stop && (state_q == RUNNING);
  assign tick     = (state_q == RUNNING) && (presc_q == PMAX);

  always_comb begin
    state_d = state_q;
    value_d = value_q;
    snap_d  = snap_q;
    presc_d = presc_q;
    lap_d   = lap_q;
    exp_d   = 1'b0;
    wrap_d  = 1'b0;
    if (clear) begin
      value_d = '0;
      presc_d = '0;
      lap_d   = 1'b0;
      state_d = STOPPED;
    end else if (load && (state_q != RUNNING)) begin
      value_d = clampv(load_val);
      presc_d = '0;
      lap_d   = 1'b0;
      state_d = STOPPED;
    end else begin
      unique case (1'b1)
        start_ok: state_d = RUNNING;
        stop_now: state_d = STOPPED;
        default: ;
      endcase
      if (lap) begin
        if (lap_q) begin
          lap_d = 1'b0;
        end else if (state_q == RUNNING) begin
          lap_d  = 1'b1;
          snap_d = value_q;
        end
      end
      // a stop in the tick cycle swallows the tick entirely
      if ((state_q == RUNNING) && !stop_now) begin
        if (tick) begin
          presc_d = '0;
          value_d = step_val(value_q, mode);
          if (mode && (value_q == 28'h1)) begin
            exp_d   = 1'b1;
            state_d = DONE;
          end
          if (!mode && (value_q == MAXV)) wrap_d = 1'b1;
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
    end
    disp_d = lap_d ? snap_d : value_d;
    upd_d  = (disp_d != disp_bcd);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= STOPPED;
      value_q <= '0;
      snap_q  <= '0;
      presc_q <= '0;
      lap_q   <= 1'b0;
      exp_q   <= 1'b0;
      wrap_q  <= 1'b0;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      snap_q  <= snap_d;
      presc_q <= presc_d;
      lap_q   <= lap_d;
      exp_q   <= exp_d;
      wrap_q  <= wrap_d;
      upd_q   <= upd_d;
    end
  end

  assign disp_bcd = lap_q ? snap_q : value_q;
  assign running  = (state_q == RUNNING);
  assign lap_hold = lap_q;
  assign expired  = exp_q;
  assign wrapped  = wrap_q;
  assign update   = upd_q;

endmodule

// File: tb/tb_stopwatch_timer.sv
// Directed vector bench for stopwatch_timer at N = 10 clocks per tick.
// Each record is one command edge plus w idle edges, then a state check.
module tb_stopwatch_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_stop, lap, clear, load, mode;
  logic [27:0] load_val;
  logic [27:0] disp_bcd;
  logic        running, lap_hold, expired, wrapped, update;

  stopwatch_timer #(
    .CLK_FREQ(100),
    .TICK_HZ (10),
    .HOUR_MAX(9)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start_stop(start_stop),
    .lap       (lap),
    .clear     (clear),
    .load      (load),
    .load_val  (load_val),
    .mode      (mode),
    .disp_bcd  (disp_bcd),
    .running   (running),
    .lap_hold  (lap_hold),
    .expired   (expired),
    .wrapped   (wrapped),
    .update    (update)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ss, lp, clr, ld;
    logic [27:0] lv;
    logic        md;
    int          w;
    logic [27:0] e_disp;
    logic        e_run, e_lap;
    int          e_upd, e_exp, e_wrap;
  } vec_t;

  vec_t tbl[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   c_upd, c_exp, c_wrap;
  int   upd_at[$];

  function automatic vec_t mk(
    input logic ss, lp, clr, ld,
    input logic [27:0] lv,
    input logic md,
    input int w,
    input logic [27:0] ed,
    input logic er, el,
    input int eu, ee, ew
  );
    vec_t v;
    v.ss = ss; v.lp = lp; v.clr = clr; v.ld = ld;
    v.lv = lv; v.md = md; v.w = w;
    v.e_disp = ed; v.e_run = er; v.e_lap = el;
    v.e_upd = eu; v.e_exp = ee; v.e_wrap = ew;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s vec%0d: got %h expected %h", nm, idx, act, exp);
    else
      n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (update) begin
      c_upd++;
      upd_at.push_back(cyc);
    end
    if (expired) c_exp++;
    if (wrapped) c_wrap++;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    c_upd = 0; c_exp = 0; c_wrap = 0;
    start_stop = v.ss; lap = v.lp; clear = v.clr; load = v.ld;
    load_val = v.lv; mode = v.md;
    step();
    start_stop = 0; lap = 0; clear = 0; load = 0;
    for (int i = 0; i < v.w; i++) step();
    chk("disp",    idx, 32'(disp_bcd), 32'(v.e_disp));
    chk("running", idx, 32'(running),  32'(v.e_run));
    chk("lap",     idx, 32'(lap_hold), 32'(v.e_lap));
    chk("updates", idx, c_upd,  v.e_upd);
    chk("expired", idx, c_exp,  v.e_exp);
    chk("wrapped", idx, c_wrap, v.e_wrap);
  endtask

  initial begin
    int s0, bad;
    rst = 1; start_stop = 0; lap = 0; clear = 0; load = 0;
    load_val = '0; mode = 0;
    #12;
    chk("rst_disp", -1, 32'(disp_bcd), 0);
    chk("rst_run",  -1, 32'(running),  0);
    chk("rst_lap",  -1, 32'(lap_hold), 0);
    chk("rst_upd",  -1, 32'({expired, wrapped, update}), 0);
    @(negedge clk);
    rst = 0;

    //            ss lp cl ld lv            md  w  disp        r  l  u  e  w
    tbl.push_back(mk(1, 0, 0, 0, 28'h0,       0, 100, 28'h0000010, 1, 0, 10, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 28'h0,       0, 0,   28'h0000010, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 28'h0,       0, 0,   28'h0,       0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 28'h0,       0, 0,   28'h0,       0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 28'h0959599, 0, 0,   28'h0959599, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 28'h0,       0, 10,  28'h0,       1, 0, 1, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 28'h0,       0, 0,   28'h0,       0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 28'h00A7F6A, 0, 0,   28'h0057569, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 28'h9AFFFFF, 0, 0,   28'h0959599, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 28'h0000003, 1, 0,   28'h0000003, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 28'h0,       1, 30,  28'h0,       0, 0, 3, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 28'h0,       1, 20,  28'h0,       0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 28'h0,       1, 0,   28'h0,       0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 28'h0,       1, 20,  28'h0,       0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 28'h0,       0, 50,  28'h0000005, 1, 0, 5, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 28'h0,       0, 20,  28'h0000005, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 28'h0,       0, 0,   28'h0000007, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 28'h0000333, 0, 0,   28'h0000007, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 28'h0,       0, 0,   28'h0,       0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 28'h0,       0, 49,  28'h0000004, 1, 0, 4, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 28'h0,       0, 0,   28'h0000004, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 28'h0,       0, 3,   28'h0000004, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 28'h0,       0, 0,   28'h0000004, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 28'h0,       0, 0,   28'h0000005, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 28'h0,       0, 8,   28'h0000005, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 28'h0,       0, 0,   28'h0000006, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 28'h0012345, 0, 0,   28'h0,       0, 0, 1, 0, 0));

    foreach (tbl[i]) begin
      if (i == 0) begin
        upd_at.delete();
        s0 = cyc + 1;
      end
      run_vec(tbl[i], i);
      if (i == 0) begin
        bad = 0;
        for (int k = 1; k < upd_at.size(); k++)
          if (upd_at[k] - upd_at[k-1] != 10) bad++;
        chk("upd_spacing", 0, bad, 0);
        if (upd_at.size() > 0)
          chk("first_tick", 0, upd_at[0] - s0, 10);
      end
    end

    // asynchronous reset in the middle of a run with lap held
    run_vec(mk(0, 0, 0, 1, 28'h0012345, 0, 0,  28'h0012345, 0, 0, 1, 0, 0), 100);
    run_vec(mk(1, 0, 0, 0, 28'h0,       0, 15, 28'h0012346, 1, 0, 1, 0, 0), 101);
    run_vec(mk(0, 1, 0, 0, 28'h0,       0, 3,  28'h0012346, 1, 1, 0, 0, 0), 102);
    #2;
    rst = 1;
    #1;
    chk("arst_disp", 103, 32'(disp_bcd), 0);
    chk("arst_run",  103, 32'(running),  0);
    chk("arst_lap",  103, 32'(lap_hold), 0);
    chk("arst_flag", 103, 32'({expired, wrapped, update}), 0);
    @(negedge clk);
    rst = 0;
    run_vec(mk(0, 0, 0, 0, 28'h0, 0, 5,  28'h0,       0, 0, 0, 0, 0), 104);
    run_vec(mk(1, 0, 0, 0, 28'h0, 0, 10, 28'h0000001, 1, 0, 1, 0, 0), 105);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
